// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip memory between several
// Avalon-style data masters, with bounded burst hold and 1-cycle read return.
module shared_mem_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_WORDS   = 25600,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
  input  logic [NUM_MASTERS-1:0]          m_read,
  input  logic [NUM_MASTERS-1:0]          m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
  output logic [NUM_MASTERS-1:0]          m_waitrequest,
  output logic [NUM_MASTERS*DATA_W-1:0]   m_readdata,
  output logic [NUM_MASTERS-1:0]          m_readdatavalid,
  output logic [ADDR_W-1:0]               mem_address,
  output logic [DATA_W/8-1:0]             mem_byteenable,
  output logic                            mem_chipselect,
  output logic                            mem_write,
  output logic [DATA_W-1:0]               mem_writedata,
  output logic                            mem_clken,
  input  logic [DATA_W-1:0]               mem_readdata,
  output logic                            err_oor,
  output logic                            err_rw
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned HOLD_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_BURST - 1);

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] gnt_onehot;
  logic                   gnt_valid;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       rd_owner;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   have_grant;
  logic                   rd_pend;
  logic                   rd_oor;
  logic [ADDR_W-1:0]      w_addr;
  logic [BE_W-1:0]        w_be;
  logic [DATA_W-1:0]      w_wdata;
  logic                   w_rd;
  logic                   w_wr;
  logic                   w_oor;

  // The hold path only applies once a real grant exists; straight out of reset
  // the search starts at last_grant+1, so master 0 wins first.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    req       = m_read | m_write;
    gnt_valid = 1'b0;
    winner    = '0;
    if (have_grant && req[last_grant] && (hold_cnt < HOLD_MAX)) begin
      gnt_valid = 1'b1;
      winner    = last_grant;
    end else begin
      for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
        cand = (32'(last_grant) + k) % NUM_MASTERS;
        if (!gnt_valid && req[IDX_W'(cand)]) begin
          gnt_valid = 1'b1;
          winner    = IDX_W'(cand);
        end
      end
    end
    if (!reset_n) gnt_valid = 1'b0;
  end

  always_comb begin
    gnt_onehot = '0;
    w_addr     = '0;
    w_be       = '0;
    w_wdata    = '0;
    w_rd       = 1'b0;
    w_wr       = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_valid && (winner == IDX_W'(i))) begin
        gnt_onehot[i] = 1'b1;
        w_addr        = m_address[i*ADDR_W +: ADDR_W];
        w_be          = m_byteenable[i*BE_W +: BE_W];
        w_wdata       = m_writedata[i*DATA_W +: DATA_W];
        w_rd          = m_read[i];
        w_wr          = m_write[i];
      end
    end
    w_oor = gnt_valid && (32'(w_addr) >= MEM_WORDS);
  end

  always_comb begin
    m_waitrequest  = reset_n ? (req & ~gnt_onehot) : '1;
    mem_clken      = reset_n;
    mem_chipselect = gnt_valid && !w_oor;
    mem_write      = gnt_valid && !w_oor && w_wr;
    mem_address    = w_addr;
    mem_byteenable = w_be;
    mem_writedata  = w_wr ? w_wdata : '0;
    m_readdata     = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      m_readdatavalid[i] = reset_n && rd_pend && (rd_owner == IDX_W'(i));
      if (m_readdatavalid[i] && !rd_oor) m_readdata[i*DATA_W +: DATA_W] = mem_readdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= IDX_W'(NUM_MASTERS - 1);
      hold_cnt   <= '0;
      have_grant <= 1'b0;
      rd_pend    <= 1'b0;
      rd_owner   <= '0;
      rd_oor     <= 1'b0;
      err_oor    <= 1'b0;
      err_rw     <= 1'b0;
    end else begin
      // A write wins over a simultaneous read, so no response is owed then.
      rd_pend  <= gnt_valid && w_rd && !w_wr;
      rd_owner <= winner;
      rd_oor   <= w_oor;
      if (gnt_valid) begin
        have_grant <= 1'b1;
        last_grant <= winner;
        if (have_grant && (winner == last_grant)) begin
          if (hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);
        end else begin
          hold_cnt <= '0;
        end
        if (w_oor) err_oor <= 1'b1;
        if (w_rd && w_wr) err_rw <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter with a behavioural 1-cycle memory.
module tb_shared_mem_arbiter;

  localparam int NM = 2;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int MW = 25600;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NM*AW-1:0]  m_address;
  logic [NM*4-1:0]   m_byteenable;
  logic [NM-1:0]     m_read;
  logic [NM-1:0]     m_write;
  logic [NM*DW-1:0]  m_writedata;
  logic [NM-1:0]     m_waitrequest;
  logic [NM*DW-1:0]  m_readdata;
  logic [NM-1:0]     m_readdatavalid;
  logic [AW-1:0]     mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DW-1:0]     mem_writedata;
  logic              mem_clken;
  logic [DW-1:0]     mem_readdata;
  logic              err_oor;
  logic              err_rw;

  always #5 clk = ~clk;

  shared_mem_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW), .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_byteenable(m_byteenable),
    .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .err_oor(err_oor), .err_rw(err_rw)
  );

  // Memory returns a poison word when not selected so stray data is visible.
  logic [31:0] mem_arr [0:MW-1];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      mem_readdata <= mem_arr[mem_address];
    end else begin
      mem_readdata <= 32'hDEADBEEF;
    end
  end

  typedef struct {
    int          owner;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] shadow [int];
  int          checks   = 0;
  int          failures = 0;
  int          last_winner;
  logic [31:0] last_rsp;
  logic        snap_cs, snap_we;
  logic [AW-1:0] snap_addr;
  logic [31:0] snap_wd;
  logic [NM-1:0] snap_wait;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_shadow(input int a);
    return shadow.exists(a) ? shadow[a] : 32'h0;
  endfunction

  task automatic idle();
    m_read = '0; m_write = '0; m_address = '0; m_byteenable = '0; m_writedata = '0;
  endtask

  task automatic cmd(input int m, input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    m_read[m]                = rd;
    m_write[m]               = wr;
    m_address[m*AW +: AW]    = a;
    m_writedata[m*DW +: DW]  = d;
    m_byteenable[m*4 +: 4]   = be;
  endtask

  task automatic check_rsp();
    rsp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rdv_owner", 32'(m_readdatavalid), 32'(1 << e.owner));
      check("rdata", m_readdata[e.owner*DW +: DW], e.data);
      for (int i = 0; i < NM; i++)
        if (i != e.owner) check("rdata_other_lane", m_readdata[i*DW +: DW], 32'h0);
      last_rsp = m_readdata[e.owner*DW +: DW];
    end else if (m_readdatavalid != '0) begin
      check("rdv_spurious", 32'(m_readdatavalid), 32'h0);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    int g, n;
    logic [AW-1:0] a;
    logic [31:0] v, wd;
    logic [3:0] be;
    rsp_t r;
    #1;
    snap_cs = mem_chipselect; snap_we = mem_write; snap_addr = mem_address;
    snap_wd = mem_writedata;  snap_wait = m_waitrequest;
    g = -1; n = 0;
    for (int i = 0; i < NM; i++)
      if ((m_read[i] | m_write[i]) && !m_waitrequest[i]) begin g = i; n++; end
    if (reset_n && ((m_read | m_write) != '0)) check("grant_count", n, 1);
    last_winner = g;
    if (g >= 0) begin
      a  = m_address[g*AW +: AW];
      wd = m_writedata[g*DW +: DW];
      be = m_byteenable[g*4 +: 4];
      if (m_write[g]) begin
        if (int'(a) < MW) begin
          v = rd_shadow(int'(a));
          for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
          shadow[int'(a)] = v;
        end
      end else if (m_read[g]) begin
        r.owner = g;
        r.data  = (int'(a) < MW) ? rd_shadow(int'(a)) : 32'h0;
        exp_q.push_back(r);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_rsp();
  endtask

  int rr_exp [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    cmd(0, 1, 0, 15'h10, 32'h0, 4'hF);
    cmd(1, 1, 0, 15'h30, 32'h0, 4'hF);
    #1;
    check("rst_wait", 32'(m_waitrequest), 32'h3);
    check("rst_rdv", 32'(m_readdatavalid), 32'h0);
    check("rst_rdata", m_readdata[31:0] | m_readdata[63:32], 32'h0);
    check("rst_cs", 32'(mem_chipselect), 32'h0);
    check("rst_we", 32'(mem_write), 32'h0);
    check("rst_clken", 32'(mem_clken), 32'h0);
    check("rst_err", {30'h0, err_oor, err_rw}, 32'h0);
    @(negedge clk);
    idle();
    reset_n = 1'b1;
    #1;
    check("clken_run", 32'(mem_clken), 32'h1);
    @(negedge clk);

    // Single master write then read-back
    cmd(0, 0, 1, 15'h10, 32'hCAFEF00D, 4'hF);
    tick();
    check("t1_wr_wait", 32'(snap_wait), 32'h0);
    check("t1_wr_cs_we", {30'h0, snap_cs, snap_we}, 32'h3);
    check("t1_wr_addr", 32'(snap_addr), 32'h10);
    check("t1_wr_data", snap_wd, 32'hCAFEF00D);
    idle();
    cmd(0, 1, 0, 15'h10, 32'h0, 4'hF);
    tick();
    check("t1_rd_wait", 32'(snap_wait), 32'h0);
    check("t1_rd_we", 32'(snap_we), 32'h0);
    check("t1_rd_value", last_rsp, 32'hCAFEF00D);
    idle();
    tick();
    check("idle_cs_we", {30'h0, snap_cs, snap_we}, 32'h0);
    check("idle_addr", 32'(snap_addr), 32'h0);
    check("idle_wdata", snap_wd, 32'h0);
    check("idle_wait", 32'(snap_wait), 32'h0);

    // Byte-lane merge from master 1
    cmd(1, 0, 1, 15'h30, 32'h11223344, 4'hF);
    tick();
    cmd(1, 0, 1, 15'h30, 32'h000000AA, 4'h1);
    tick();
    cmd(1, 1, 0, 15'h30, 32'h0, 4'hF);
    tick();
    check("byte_merge", last_rsp, 32'h112233AA);

    // Reset arriving the cycle after a read grant drops the response
    idle();
    cmd(0, 1, 0, 15'h10, 32'h0, 4'hF);
    #1;
    check("rstmid_grant", 32'(m_waitrequest), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    idle();
    #1;
    check("rstmid_rdv", 32'(m_readdatavalid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rstmid_rdv_after", 32'(m_readdatavalid), 32'h0);
    @(negedge clk);

    // Both masters reading continuously: burst-limited round-robin
    cmd(0, 1, 0, 15'h10, 32'h0, 4'hF);
    cmd(1, 1, 0, 15'h30, 32'h0, 4'hF);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("rr_seq", last_winner, rr_exp[k]);
    end

    // Out-of-range read from master 1
    idle();
    tick();
    check("err_oor_clear", 32'(err_oor), 32'h0);
    cmd(1, 1, 0, 15'd25600, 32'h0, 4'hF);
    tick();
    check("oor_winner", last_winner, 1);
    check("oor_cs", 32'(snap_cs), 32'h0);
    check("oor_value", last_rsp, 32'h0);
    check("err_oor_set", 32'(err_oor), 32'h1);

    // Read and write together: write wins, read is dropped
    idle();
    check("err_rw_clear", 32'(err_rw), 32'h0);
    cmd(0, 1, 1, 15'h5, 32'h1, 4'hF);
    tick();
    check("rw_cs_we", {30'h0, snap_cs, snap_we}, 32'h3);
    check("err_rw_set", 32'(err_rw), 32'h1);
    idle();
    cmd(0, 1, 0, 15'h5, 32'h0, 4'hF);
    tick();
    check("rw_word", last_rsp, 32'h1);
    check("err_oor_sticky", 32'(err_oor), 32'h1);

    idle();
    tick();
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
